mem_lsu: RTL and testbench

MEM-stage load/store unit; the consumer of the EX/MEM pipeline register outputs (address, store data, memrw, load/store type) in the non-forwarding pipeline.
- Converts one memory op into a req/ack data-bus transaction, stalling the pipeline while the transaction is outstanding.
- Returns sign/zero-extended load data and flags misaligned accesses and bus timeouts.
- One op in flight at a time.

---
 rtl/mem_lsu.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : MEM-stage load/store unit. Turns one EX/MEM memory op into a
//             req/ack data-bus transaction, stalls the pipeline while it is
//             outstanding, and returns extended load data plus
//             misaligned/error flags.
//  Ports    : i_clk, i_rst_n         - clock, async active-low reset
//             i_req, i_alu, i_rs2,   - op from EX/MEM (address, store data,
//             i_memrw, i_load_type,    direction, access types)
//             i_store_type
//             o_stall, o_done        - pipeline hold / one-cycle completion
//             o_ld_data, o_misaligned, o_err - result, valid with o_done
//             o_bus_*, i_bus_*       - req/ack data bus
//  Revision : 1.0  initial release
// ============================================================================
module mem_lsu #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_rs2,
    input  logic        i_memrw,
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_store_type,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             bus_we_q,  bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q,  bus_be_d;
    logic [2:0]       ld_type_q, ld_type_d;
    logic [1:0]       lane_q,    lane_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             mis_q,     mis_d;
    logic             err_q,     err_d;

    logic             illegal;
    logic             misal;
    logic [31:0]      rd_shifted;
    logic [15:0]      rd_half;
    logic [31:0]      ld_ext;

    // Legality and alignment of the op currently presented by EX/MEM.
    always_comb begin
        if (i_memrw) begin
            illegal = (i_store_type == 2'b11);
            misal   = ((i_store_type == 2'b01) && i_alu[0]) ||
                      ((i_store_type == 2'b10) && (i_alu[1:0] != 2'b00));
        end else begin
            illegal = !((i_load_type == 3'b000) || (i_load_type == 3'b001) ||
                        (i_load_type == 3'b010) || (i_load_type == 3'b100) ||
                        (i_load_type == 3'b101));
            // Low bits 01 select LH/LHU; illegal types are screened first.
            misal   = ((i_load_type[1:0] == 2'b01) && i_alu[0]) ||
                      ((i_load_type == 3'b010) && (i_alu[1:0] != 2'b00));
        end
    end

    // Load extraction from the returned word using the registered lane/type.
    always_comb begin
        rd_shifted = i_bus_rdata >> {lane_q, 3'b000};
        rd_half    = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (ld_type_q)
            3'b000:  ld_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_ext = i_bus_rdata;
            3'b100:  ld_ext = {24'd0, rd_shifted[7:0]};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        ld_type_d   = ld_type_q;
        lane_d      = lane_q;
        ld_data_d   = ld_data_q;
        mis_d       = mis_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_req) begin
                    if (illegal) begin
                        err_d     = 1'b1;
                        mis_d     = 1'b0;
                        ld_data_d = 32'd0;
                        state_d   = ST_DONE;
                    end else if (misal) begin
                        err_d     = 1'b0;
                        mis_d     = 1'b1;
                        ld_data_d = 32'd0;
                        state_d   = ST_DONE;
                    end else begin
                        bus_we_d   = i_memrw;
                        bus_addr_d = {i_alu[31:2], 2'b00};
                        ld_type_d  = i_load_type;
                        lane_d     = i_alu[1:0];
                        if (i_memrw) begin
                            case (i_store_type)
                                2'b00: begin
                                    bus_wdata_d = {4{i_rs2[7:0]}};
                                    bus_be_d    = 4'b0001 << i_alu[1:0];
                                end
                                2'b01: begin
                                    bus_wdata_d = {2{i_rs2[15:0]}};
                                    bus_be_d    = 4'b0011 << i_alu[1:0];
                                end
                                default: begin
                                    bus_wdata_d = i_rs2;
                                    bus_be_d    = 4'b1111;
                                end
                            endcase
                        end else begin
                            bus_wdata_d = 32'd0;
                            bus_be_d    = 4'b1111;
                        end
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (i_bus_ack) begin
                    ld_data_d = bus_we_q ? 32'd0 : ld_ext;
                    err_d     = 1'b0;
                    mis_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ld_data_d = 32'd0;
                    err_d     = 1'b1;
                    mis_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // The op is still visible on i_req here; it must not restart.
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            ld_type_q   <= 3'd0;
            lane_q      <= 2'd0;
            ld_data_q   <= 32'd0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ld_type_q   <= ld_type_d;
            lane_q      <= lane_d;
            ld_data_q   <= ld_data_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
        end
    end

    // Stall is gated by reset so every output reads 0 while reset is held,
    // even if EX/MEM keeps presenting an op.
    assign o_stall      = i_rst_n & ((state_q == ST_BUSY) ||
                                     ((state_q == ST_IDLE) && i_req));
    assign o_done       = (state_q == ST_DONE);
    assign o_bus_req    = (state_q == ST_BUSY);
    assign o_bus_we     = bus_we_q;
    assign o_bus_addr   = bus_addr_q;
    assign o_bus_wdata  = bus_wdata_q;
    assign o_bus_be     = bus_be_q;
    assign o_ld_data    = ld_data_q;
    assign o_misaligned = mis_q;
    assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Self-checking bench for mem_lsu. A vector table drives ops and
//             pushes expected results to a scoreboard queue; a monitor pops
//             and compares on every o_done. Hand sequences cover result hold,
//             DONE ignoring i_req, and reset while busy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_alu = '0;
    logic [31:0] i_rs2 = '0;
    logic        i_memrw = 1'b0;
    logic [2:0]  i_load_type = '0;
    logic [1:0]  i_store_type = '0;
    logic        o_stall, o_done, o_misaligned, o_err;
    logic [31:0] o_ld_data;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_ack = 1'b0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_alu(i_alu),
        .i_rs2(i_rs2), .i_memrw(i_memrw), .i_load_type(i_load_type),
        .i_store_type(i_store_type), .o_stall(o_stall), .o_done(o_done),
        .o_ld_data(o_ld_data), .o_misaligned(o_misaligned), .o_err(o_err),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack)
    );

    // ack_dly: BUSY cycle index (0-based) carrying the ack; -1 = op never
    // reaches the bus; >= TIMEOUT = ack withheld.
    typedef struct {
        logic        memrw;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_dly;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_ld;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        err;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic memrw, input logic [2:0] lt,
                                input logic [1:0] st, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [31:0] rdata,
                                input int ack, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] ld,
                                input logic mis, input logic err);
        vec_t v;
        v.memrw = memrw; v.lt = lt; v.st = st; v.addr = addr; v.rs2 = rs2;
        v.rdata = rdata; v.ack_dly = ack; v.e_wdata = wd; v.e_be = be;
        v.e_ld = ld; v.e_mis = mis; v.e_err = err;
        return v;
    endfunction

    // Scoreboard monitor: every completion must match the oldest pending op.
    always @(negedge clk) begin
        #1;
        if (i_rst_n && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: o_done got 1 expected 0 (no op pending)");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("v%0d_ld_data", mon_e.id), o_ld_data, mon_e.ld);
                chk($sformatf("v%0d_misaligned", mon_e.id), {31'd0, o_misaligned}, {31'd0, mon_e.mis});
                chk($sformatf("v%0d_err", mon_e.id), {31'd0, o_err}, {31'd0, mon_e.err});
                chk($sformatf("v%0d_stall_in_done", mon_e.id), {31'd0, o_stall}, 32'd0);
            end
        end
    end

    task automatic run_op(input vec_t v, input int id, input bit hold_req);
        int   cyc, stalls, reqs, e_done, e_req;
        bit   done;
        exp_t e;
        @(negedge clk);
        i_req = 1'b1; i_memrw = v.memrw; i_load_type = v.lt;
        i_store_type = v.st; i_alu = v.addr; i_rs2 = v.rs2; i_bus_ack = 1'b0;
        e.ld = v.e_ld; e.mis = v.e_mis; e.err = v.e_err; e.id = id;
        sb.push_back(e);
        if (v.ack_dly < 0) begin
            e_done = 1; e_req = 0;
        end else if (v.ack_dly >= TIMEOUT) begin
            e_done = TIMEOUT + 1; e_req = TIMEOUT;
        end else begin
            e_done = v.ack_dly + 2; e_req = v.ack_dly + 1;
        end
        cyc = 0; stalls = 0; reqs = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (o_done) begin
                done = 1'b1;
            end else begin
                if (o_stall) stalls++;
                if (o_bus_req) begin
                    chk($sformatf("v%0d_bus_addr", id), o_bus_addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d_bus_we", id), {31'd0, o_bus_we}, {31'd0, v.memrw});
                    chk($sformatf("v%0d_bus_be", id), {28'd0, o_bus_be}, {28'd0, v.e_be});
                    if (v.memrw)
                        chk($sformatf("v%0d_bus_wdata", id), o_bus_wdata, v.e_wdata);
                    reqs++;
                    if (reqs - 1 == v.ack_dly) begin
                        i_bus_ack = 1'b1; i_bus_rdata = v.rdata;
                    end else begin
                        i_bus_ack = 1'b0; i_bus_rdata = $urandom;
                    end
                end else begin
                    i_bus_ack = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        i_bus_ack = 1'b0;
        if (!hold_req) i_req = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL v%0d_done_timeout: no o_done after %0d cycles (expected at %0d)", id, cyc, e_done);
        end else begin
            chk($sformatf("v%0d_latency", id), cyc, e_done);
            chk($sformatf("v%0d_stall_cycles", id), stalls, e_done);
            chk($sformatf("v%0d_req_cycles", id), reqs, e_req);
        end
    endtask

    initial begin
        vt[0]  = mk(0, 3'b010, 2'b00, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 0, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0);
        vt[1]  = mk(0, 3'b000, 2'b00, 32'h1000_0003, 32'h0, 32'h8011_2233, 2, 32'h0, 4'hF, 32'hFFFF_FF80, 0, 0);
        vt[2]  = mk(0, 3'b100, 2'b00, 32'h1000_0003, 32'h0, 32'h8011_2233, 0, 32'h0, 4'hF, 32'h0000_0080, 0, 0);
        vt[3]  = mk(0, 3'b101, 2'b00, 32'h1000_0002, 32'h0, 32'hBEEF_0000, 1, 32'h0, 4'hF, 32'h0000_BEEF, 0, 0);
        vt[4]  = mk(0, 3'b001, 2'b00, 32'h1000_0002, 32'h0, 32'h8001_1234, 0, 32'h0, 4'hF, 32'hFFFF_8001, 0, 0);
        vt[5]  = mk(0, 3'b001, 2'b00, 32'h1000_0000, 32'h0, 32'h1234_7FFF, 3, 32'h0, 4'hF, 32'h0000_7FFF, 0, 0);
        vt[6]  = mk(0, 3'b000, 2'b00, 32'h1000_0001, 32'h0, 32'h1122_C355, 0, 32'h0, 4'hF, 32'hFFFF_FFC3, 0, 0);
        vt[7]  = mk(0, 3'b100, 2'b00, 32'h1000_0000, 32'h0, 32'h1122_33F0, 1, 32'h0, 4'hF, 32'h0000_00F0, 0, 0);
        vt[8]  = mk(1, 3'b000, 2'b00, 32'h1000_0001, 32'h1234_56AB, 32'h5555_5555, 0, 32'hABAB_ABAB, 4'b0010, 32'h0, 0, 0);
        vt[9]  = mk(1, 3'b000, 2'b01, 32'h1000_0002, 32'h0000_CAFE, 32'h5555_5555, 1, 32'hCAFE_CAFE, 4'b1100, 32'h0, 0, 0);
        vt[10] = mk(1, 3'b000, 2'b10, 32'h1000_0004, 32'hA5A5_1234, 32'h5555_5555, 0, 32'hA5A5_1234, 4'b1111, 32'h0, 0, 0);
        vt[11] = mk(1, 3'b000, 2'b00, 32'h1000_0003, 32'hFFFF_FF5A, 32'h5555_5555, 4, 32'h5A5A_5A5A, 4'b1000, 32'h0, 0, 0);
        vt[12] = mk(1, 3'b000, 2'b10, 32'h1000_0002, 32'h1111_1111, 32'h0, -1, 32'h0, 4'h0, 32'h0, 1, 0);
        vt[13] = mk(0, 3'b011, 2'b00, 32'h1000_0004, 32'h0, 32'h0, -1, 32'h0, 4'h0, 32'h0, 0, 1);
        vt[14] = mk(0, 3'b001, 2'b00, 32'h1000_0001, 32'h0, 32'h0, -1, 32'h0, 4'h0, 32'h0, 1, 0);
        vt[15] = mk(1, 3'b000, 2'b11, 32'h1000_0000, 32'h2222_2222, 32'h0, -1, 32'h0, 4'h0, 32'h0, 0, 1);
        vt[16] = mk(0, 3'b101, 2'b00, 32'h1000_0003, 32'h0, 32'h0, -1, 32'h0, 4'h0, 32'h0, 1, 0);
        vt[17] = mk(0, 3'b010, 2'b00, 32'h1000_000C, 32'h0, 32'h0123_4567, TIMEOUT - 1, 32'h0, 4'hF, 32'h0123_4567, 0, 0);
        vt[18] = mk(0, 3'b010, 2'b00, 32'h1000_0010, 32'h0, 32'h0, 1000, 32'h0, 4'hF, 32'h0, 0, 1);

        // Reset state.
        #1 i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
        chk("rst_ld_data", o_ld_data, 32'd0);
        chk("rst_flags", {30'd0, o_misaligned, o_err}, 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, o_bus_be}, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op(vt[i], i, 1'b0);
            if (vt[i].e_mis) begin
                // Result flags persist while idle until the next completion.
                repeat (2) @(negedge clk);
                #1;
                chk($sformatf("v%0d_mis_hold", i), {31'd0, o_misaligned}, 32'd1);
                chk($sformatf("v%0d_idle_bus_req", i), {31'd0, o_bus_req}, 32'd0);
            end
        end

        // i_req still high through DONE must not restart the op.
        run_op(vt[0], 100, 1'b1);
        @(negedge clk);
        #1;
        chk("done_ignore_bus_req", {31'd0, o_bus_req}, 32'd0);
        chk("done_ignore_done", {31'd0, o_done}, 32'd0);
        chk("done_ignore_ld_hold", o_ld_data, 32'hDEAD_BEEF);
        i_req = 1'b0;
        @(negedge clk);
        #1;
        chk("done_ignore_no_restart", {31'd0, o_bus_req}, 32'd0);

        // Reset while BUSY with ack pending.
        @(negedge clk);
        i_req = 1'b1; i_memrw = 1'b0; i_load_type = 3'b010; i_alu = 32'h1000_0020;
        @(negedge clk);
        #1;
        chk("busy_before_rst", {31'd0, o_bus_req}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_req", {31'd0, o_bus_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_mid_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        run_op(vt[0], 200, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
